// File: rtl/keypad_row_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad row scanner.
// The key map and state encoding are used by the RTL and by the bench.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE_PRESS,
        HELD,
        DEBOUNCE_RELEASE
    } scan_state_t;

    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // Rows 0..3 top to bottom, columns 0..3 left to right.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Index of the lowest column reading 0; only meaningful when cols != 4'hF.
    function automatic logic [1:0] lowest_low_col(input logic [3:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_row_scanner_row_driver.sv
// Row rotation for the keypad: each row is driven low for SCAN_DIV cycles.
// freeze parks the current row; advance jumps to the next row with a fresh dwell.
module row_driver #(
    parameter int SCAN_DIV = 24000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       freeze,
    output logic [3:0] row,
    output logic [1:0] row_idx,
    output logic       sample_en
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] dwell_cnt;
    logic [1:0]       next_idx;

    assign next_idx  = row_idx + 2'd1;
    assign sample_en = (dwell_cnt == DWELL_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_cnt <= '0;
            row_idx   <= 2'd0;
            row       <= 4'b1110;
        end else if (advance || (!freeze && sample_en)) begin
            dwell_cnt <= '0;
            row_idx   <= next_idx;
            row       <= ~(4'b0001 << next_idx);
        end else if (freeze) begin
            // Parked row restarts its dwell from zero once released.
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/keypad_row_scanner.sv
// 4x4 keypad scanner: rotates rows, debounces press and release of one key,
// and emits a single key_valid pulse with the hex code per accepted press.
module keypad_row_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 24000,
    parameter int DEBOUNCE_CYCLES = 480000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_sync,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    scan_state_t      state;
    logic [DEB_W-1:0] deb_cnt;
    logic [1:0]       lat_row;
    logic [1:0]       lat_col;
    logic [1:0]       row_idx;
    logic             sample_en;
    logic             any_low;
    logic             lat_col_high;
    logic             freeze;
    logic             advance;

    assign any_low      = (col_sync != 4'hF);
    assign lat_col_high = col_sync[lat_col];

    always_comb begin
        freeze  = (state != SCAN) || (sample_en && any_low);
        advance = 1'b0;
        case (state)
            DEBOUNCE_PRESS:   advance = lat_col_high;
            DEBOUNCE_RELEASE: advance = lat_col_high && (deb_cnt == DEB_LAST);
            default:          advance = 1'b0;
        endcase
    end

    row_driver #(
        .SCAN_DIV (SCAN_DIV)
    ) u_row_driver (
        .clk       (clk),
        .reset     (reset),
        .advance   (advance),
        .freeze    (freeze),
        .row       (row),
        .row_idx   (row_idx),
        .sample_en (sample_en)
    );

    // Position latch is written on every SCAN->DEBOUNCE_PRESS entry before use.
    always_ff @(posedge clk) begin
        if (state == SCAN && sample_en && any_low) begin
            lat_row <= row_idx;
            lat_col <= lowest_low_col(col_sync);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            deb_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (sample_en && any_low) begin
                        deb_cnt <= '0;
                        state   <= DEBOUNCE_PRESS;
                    end
                end
                DEBOUNCE_PRESS: begin
                    if (lat_col_high) begin
                        state <= SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_valid <= 1'b1;
                        key_code  <= KEYMAP[lat_row][lat_col];
                        key_held  <= 1'b1;
                        state     <= HELD;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                HELD: begin
                    if (lat_col_high) begin
                        deb_cnt <= '0;
                        state   <= DEBOUNCE_RELEASE;
                    end
                end
                DEBOUNCE_RELEASE: begin
                    // A bounce back to pressed keeps the key held without a new pulse.
                    if (!lat_col_high) begin
                        state <= HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_held <= 1'b0;
                        state    <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_row_scanner.sv
// Directed bench for keypad_row_scanner with a keypad matrix model and 2-flop column sync.
module tb_keypad_row_scanner;
    import keypad_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  col_sync;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] keys  = '0;
    logic [3:0]  col_raw;
    logic [3:0]  sync1 = 4'hF;
    logic [3:0]  sync2 = 4'hF;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Pressed key at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col_raw = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && keys[r*4+c]) col_raw[c] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        sync1 <= col_raw;
        sync2 <= sync1;
    end

    assign col_sync = sync2;

    keypad_row_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col_sync  (col_sync),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Leaves the bench on the negedge right after the last reset edge (dwell count 0, row 0).
    task automatic do_reset();
        keys  = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_accept(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (key_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (row !== 4'b1110) begin fails++; $display("FAIL reset_row: got %b expected 1110", row); end
        tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL reset_code: got %h expected 0", key_code); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL reset_held: got %b expected 0", key_held); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_row;
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            exp_row = 4'b1111 ^ (4'b0001 << ((i / 4) % 4));
            tests++; if (row !== exp_row) begin fails++; $display("FAIL scan_row[%0d]: got %b expected %b", i, row, exp_row); end
            tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL scan_valid[%0d]: got %b expected 0", i, key_valid); end
            @(negedge clk);
        end
        tests++; if (row === ROW_IDLE) begin fails++; $display("FAIL scan_idle: got %b expected one-cold", row); end
    endtask

    task automatic test_hold_key();
        logic seen;
        do_reset();
        keys[2*4+1] = 1'b1;
        wait_accept(seen);
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL hold_accept: got no pulse expected key_valid"); end
        tests++; if (key_code !== 4'h8) begin fails++; $display("FAIL hold_code: got %h expected 8", key_code); end
        tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL hold_held: got %b expected 1", key_held); end
        tests++; if (row !== 4'b1011) begin fails++; $display("FAIL hold_row: got %b expected 1011", row); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL hold_repeat[%0d]: got %b expected 0", i, key_valid); end
            tests++; if (row !== 4'b1011) begin fails++; $display("FAIL hold_frozen[%0d]: got %b expected 1011", i, row); end
        end
        keys = '0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            tests++; if (key_held !== (i < 11)) begin fails++; $display("FAIL hold_release[%0d]: got %b expected %b", i, key_held, i < 11); end
            if (i < 11) begin
                tests++; if (row !== 4'b1011) begin fails++; $display("FAIL hold_release_row[%0d]: got %b expected 1011", i, row); end
            end
        end
        tests++; if (row !== 4'b0111) begin fails++; $display("FAIL hold_resume_row: got %b expected 0111", row); end
    endtask

    task automatic test_short_press();
        logic [3:0] exp_row;
        do_reset();
        keys[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3) keys = '0;
            exp_row = (i <= 5) ? 4'b1110 : (i <= 9) ? 4'b1101 : 4'b1011;
            tests++; if (row !== exp_row) begin fails++; $display("FAIL short_row[%0d]: got %b expected %b", i, row, exp_row); end
            tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL short_valid[%0d]: got %b expected 0", i, key_valid); end
        end
    endtask

    task automatic test_bounce_release();
        logic seen;
        do_reset();
        keys[1*4+1] = 1'b1;
        wait_accept(seen);
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL bounce_accept: got no pulse expected key_valid"); end
        tests++; if (key_code !== 4'h5) begin fails++; $display("FAIL bounce_code: got %h expected 5", key_code); end
        repeat (2) @(negedge clk);
        keys = '0;
        @(negedge clk);
        keys[1*4+1] = 1'b1;
        tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL bounce_held[1]: got %b expected 1", key_held); end
        @(negedge clk);
        keys = '0;
        tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL bounce_held[2]: got %b expected 1", key_held); end
        for (int i = 3; i <= 13; i++) begin
            @(negedge clk);
            tests++; if (key_held !== (i < 13)) begin fails++; $display("FAIL bounce_held[%0d]: got %b expected %b", i, key_held, i < 13); end
            tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL bounce_valid[%0d]: got %b expected 0", i, key_valid); end
        end
        tests++; if (row !== 4'b1011) begin fails++; $display("FAIL bounce_resume_row: got %b expected 1011", row); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL bounce_second[%0d]: got %b expected 0", i, key_valid); end
        end
    endtask

    task automatic test_multi_key();
        logic seen;
        do_reset();
        keys[3*4+0] = 1'b1;
        keys[3*4+2] = 1'b1;
        wait_accept(seen);
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL multi_accept: got no pulse expected key_valid"); end
        tests++; if (key_code !== 4'hE) begin fails++; $display("FAIL multi_code: got %h expected E", key_code); end
        keys[1*4+0] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL multi_extra_valid[%0d]: got %b expected 0", i, key_valid); end
            tests++; if (row !== 4'b0111) begin fails++; $display("FAIL multi_row[%0d]: got %b expected 0111", i, row); end
        end
        tests++; if (key_code !== 4'hE) begin fails++; $display("FAIL multi_code_hold: got %h expected E", key_code); end
        keys = '0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_held === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL multi_release: got key_held %b expected 0 within 40 cycles", key_held); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        do_reset();
        keys[2*4+1] = 1'b1;
        repeat (13) @(negedge clk);
        tests++; if (row !== 4'b1011) begin fails++; $display("FAIL rst_dp_frozen: got %b expected 1011", row); end
        reset = 1'b1;
        @(negedge clk);
        tests++; if (row !== 4'b1110) begin fails++; $display("FAIL rst_dp_row: got %b expected 1110", row); end
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL rst_dp_held: got %b expected 0", key_held); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL rst_dp_valid: got %b expected 0", key_valid); end
        keys  = '0;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL rst_dp_pulse[%0d]: got %b expected 0", i, key_valid); end
        end

        do_reset();
        keys[2*4+1] = 1'b1;
        wait_accept(seen);
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL rst_held_accept: got no pulse expected key_valid"); end
        repeat (3) @(negedge clk);
        tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL rst_held_pre: got %b expected 1", key_held); end
        reset = 1'b1;
        @(negedge clk);
        tests++; if (row !== 4'b1110) begin fails++; $display("FAIL rst_held_row: got %b expected 1110", row); end
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL rst_held_held: got %b expected 0", key_held); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL rst_held_valid: got %b expected 0", key_valid); end
        tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL rst_held_code: got %h expected 0", key_code); end
        keys  = '0;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_hold_key();
        test_short_press();
        test_bounce_release();
        test_multi_key();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
